rom_vector_sequencer: RTL and testbench
=======================================

// Module: rom_vector_sequencer
// PURPOSE
//  Walks the operand test-vector ROMs (A and B, 10-bit address, combinational read) from address 0
//  to NUM_VECTORS-1. For each vector it launches one FPU operation, waits for the result, then hands
//  the result to the UART transmit path over a valid/ready handshake. It sits between the two
//  vector ROMs (it drives their address) and the FPU / UART TX, and sequences a full regression run.
// PARAMETERS
//  W            32    operand/result width (32 or 64); must match the ROM W
//  NUM_VECTORS  1024  vectors per run, legal range 1..1024
// PORTS
//  clk          in   1   system clock, rising edge
//  rst          in   1   asynchronous, active-high reset
//  start        in   1   1-cycle pulse that begins a run; ignored while busy=1
//  rom_address  out  10  address to both vector ROMs
//  rom_data_a   in   W   operand A from ROM (N=0)
//  rom_data_b   in   W   operand B from ROM (N=1)
//  fpu_op_a     out  W   registered operand A to FPU
//  fpu_op_b     out  W   registered operand B to FPU
//  fpu_begin    out  1   1-cycle launch pulse to FPU
//  fpu_ready    in   1   FPU result valid; sampled only in WAIT
//  fpu_result   in   W   FPU result
//  tx_valid     out  1   result word valid to UART TX
//  tx_data      out  W   result word
//  tx_ready     in   1   UART TX accepts word when tx_valid & tx_ready
//  busy         out  1   1 whenever state != IDLE
//  done         out  1   1-cycle pulse after last vector is accepted by TX
//  vec_index    out  10  index of the vector in flight
//  checksum     out  W   XOR of all results in current run (see CONFIGURATION)
// BEHAVIOUR
//  - All outputs are registered. Reset (async, any time): state=IDLE; all outputs 0,
//    rom_address=0, checksum=0. Reset mid-run abandons the run; no done pulse is issued.
//  - States: IDLE -> FETCH -> LAUNCH -> WAIT -> SEND -> (FETCH | IDLE).
//  - IDLE: on start=1, vec_index=0, rom_address=0, checksum cleared, go to FETCH.
//  - FETCH (1 cycle): ROM data is valid (combinational ROM). Latch rom_data_a/b into
//    fpu_op_a/b. Go to LAUNCH.
//  - LAUNCH (1 cycle): fpu_begin=1 during exactly this cycle; operands are stable from this cycle
//    until the next FETCH. Go to WAIT.
//  - WAIT: hold until fpu_ready=1, with no timeout. On fpu_ready, latch tx_data=fpu_result,
//    set tx_valid=1, go to SEND. A fpu_ready in the same cycle as fpu_begin is ignored.
//  - SEND: tx_valid and tx_data are held stable until tx_ready=1. On handshake, tx_valid=0.
//      - If vec_index==NUM_VECTORS-1: done=1 for one cycle, rom_address=0, go to IDLE.
//      - Else: vec_index+1, rom_address+1, go to FETCH.
//  - Minimum period per vector is 4 cycles, when fpu_ready and tx_ready are already high.
//  - Wrap-around: the index never exceeds NUM_VECTORS-1. With NUM_VECTORS=1024, address 1023 is
//    last and the address never wraps mid-run. start asserted together with the final handshake is
//    ignored, because busy is still 1 in that cycle.
//  - fpu_ready and tx_ready are don't-care outside WAIT and SEND respectively.
// CONFIGURATION
//  ROMSEQ_CHECKSUM_EN defined:
//    - checksum = checksum ^ fpu_result at each WAIT->SEND capture.
//    - checksum is cleared on an accepted start and holds its final value after done until the
//      next start.
//  Not defined:
//    - checksum is tied to 0 and no accumulator register is built.
// TESTING
//  1. Reset then idle: rst=1 pulse -> all outputs 0, busy=0. Hold tx_ready=1 and fpu_ready=1,
//     no start -> no fpu_begin ever.
//  2. NUM_VECTORS=4, ROM A=i+1, ROM B=2i, FPU model returns A+B after 3 cycles, tx_ready=1 ->
//     tx_data sequence 1,4,7,10. Exactly 4 fpu_begin pulses. done pulses once, 1 cycle after the
//     4th handshake.
//  3. Back-pressure: tx_ready=0 for 20 cycles in vector 0 -> tx_valid stays 1 and tx_data stays
//     constant, rom_address stays 0, no fpu_begin. Release -> run continues with index 1.
//  4. start pulsed during WAIT of vector 2 -> ignored; run completes with exactly NUM_VECTORS
//     results.
//  5. Full depth NUM_VECTORS=1024 -> last rom_address=1023, then 0 in IDLE. 1024 tx handshakes.
//  6. rst asserted in WAIT of vector 5 -> immediate IDLE, outputs 0, no done. A new start
//     restarts at address 0. With ROMSEQ_CHECKSUM_EN: after test 2, checksum=1^4^7^10=8.

Source files
------------

// File: rtl/rom_vector_sequencer.sv
// Walks the A/B operand ROMs, launches one FPU op per vector and streams each result to UART TX.
// Optional XOR checksum of all results when ROMSEQ_CHECKSUM_EN is defined.
module rom_vector_sequencer #(
   parameter int W           = 32,
   parameter int NUM_VECTORS = 1024
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   output logic [9:0]   rom_address,
   input  logic [W-1:0] rom_data_a,
   input  logic [W-1:0] rom_data_b,
   output logic [W-1:0] fpu_op_a,
   output logic [W-1:0] fpu_op_b,
   output logic         fpu_begin,
   input  logic         fpu_ready,
   input  logic [W-1:0] fpu_result,
   output logic         tx_valid,
   output logic [W-1:0] tx_data,
   input  logic         tx_ready,
   output logic         busy,
   output logic         done,
   output logic [9:0]   vec_index,
   output logic [W-1:0] checksum
);

   localparam logic [9:0] LAST_IDX = 10'(NUM_VECTORS - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_LAUNCH,
      S_WAIT,
      S_SEND
   } state_t;

   state_t state, state_n;

   logic last_vec;
   assign last_vec = (vec_index == LAST_IDX);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_IDLE;
      else     state <= state_n;
   end

   always_comb begin
      state_n = state;
      case (state)
         S_IDLE:   if (start) state_n = S_FETCH;
         S_FETCH:  state_n = S_LAUNCH;
         S_LAUNCH: state_n = S_WAIT;
         S_WAIT:   if (fpu_ready) state_n = S_SEND;
         S_SEND:   if (tx_ready) state_n = last_vec ? S_IDLE : S_FETCH;
         default:  state_n = S_IDLE;
      endcase
   end

   // fpu_begin is set on the FETCH->LAUNCH edge so it is high for exactly the LAUNCH cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rom_address <= '0;
         vec_index   <= '0;
         fpu_op_a    <= '0;
         fpu_op_b    <= '0;
         fpu_begin   <= 1'b0;
         tx_valid    <= 1'b0;
         tx_data     <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
      end else begin
         fpu_begin <= 1'b0;
         done      <= 1'b0;
         busy      <= (state_n != S_IDLE);
         case (state)
            S_IDLE: begin
               if (start) begin
                  vec_index   <= '0;
                  rom_address <= '0;
               end
            end
            S_FETCH: begin
               fpu_op_a  <= rom_data_a;
               fpu_op_b  <= rom_data_b;
               fpu_begin <= 1'b1;
            end
            S_WAIT: begin
               if (fpu_ready) begin
                  tx_data  <= fpu_result;
                  tx_valid <= 1'b1;
               end
            end
            S_SEND: begin
               if (tx_ready) begin
                  tx_valid <= 1'b0;
                  if (last_vec) begin
                     done        <= 1'b1;
                     rom_address <= '0;
                  end else begin
                     vec_index   <= vec_index + 10'd1;
                     rom_address <= rom_address + 10'd1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

`ifdef ROMSEQ_CHECKSUM_EN
   // Accumulator keeps its final value after done until the next accepted start.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                                checksum <= '0;
      else if (state == S_IDLE && start)      checksum <= '0;
      else if (state == S_WAIT && fpu_ready)  checksum <= checksum ^ fpu_result;
   end
`else
   assign checksum = '0;
`endif

endmodule

// File: tb/tb_rom_vector_sequencer.sv
// Directed bench: a 4-vector instance for function/back-pressure checks, a 1024-vector one for depth/reset.
module tb_rom_vector_sequencer;

   localparam int W = 32;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int errs = 0;
   int checks = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // ---------------- small instance: NUM_VECTORS=4 ----------------
   logic         start0 = 1'b0;
   logic [9:0]   rom_address0, vec_index0;
   logic [W-1:0] rom_data_a0, rom_data_b0, fpu_op_a0, fpu_op_b0, fpu_result0, tx_data0, checksum0;
   logic         fpu_begin0, fpu_ready0, tx_valid0, busy0, done0;
   logic         tx_ready0 = 1'b1;
   logic         force_rdy = 1'b0;

   assign rom_data_a0 = 32'(rom_address0) + 32'd1;
   assign rom_data_b0 = 32'(rom_address0) * 32'd2;

   // FPU model: result A+B ready a few cycles after each launch
   int           fcnt = 0;
   logic         fpend = 1'b0;
   logic [W-1:0] fres = '0;
   always @(posedge clk) begin
      if (fpu_begin0) begin
         fcnt  <= 3;
         fpend <= 1'b1;
         fres  <= fpu_op_a0 + fpu_op_b0;
      end else if (fcnt != 0) fcnt <= fcnt - 1;
   end
   assign fpu_ready0  = force_rdy | (fpend && fcnt == 0 && !fpu_begin0);
   assign fpu_result0 = fres;

   rom_vector_sequencer #(.W(W), .NUM_VECTORS(4)) dut0 (
      .clk(clk), .rst(rst), .start(start0), .rom_address(rom_address0),
      .rom_data_a(rom_data_a0), .rom_data_b(rom_data_b0),
      .fpu_op_a(fpu_op_a0), .fpu_op_b(fpu_op_b0), .fpu_begin(fpu_begin0),
      .fpu_ready(fpu_ready0), .fpu_result(fpu_result0),
      .tx_valid(tx_valid0), .tx_data(tx_data0), .tx_ready(tx_ready0),
      .busy(busy0), .done(done0), .vec_index(vec_index0), .checksum(checksum0)
   );

   // ---------------- full-depth instance: NUM_VECTORS=1024 ----------------
   logic         start1 = 1'b0;
   logic         rdy1 = 1'b1;
   logic [9:0]   rom_address1, vec_index1;
   logic [W-1:0] rom_data_a1, rom_data_b1, fpu_op_a1, fpu_op_b1, fpu_result1, tx_data1, checksum1;
   logic         fpu_begin1, tx_valid1, busy1, done1;

   assign rom_data_a1 = 32'(rom_address1);
   assign rom_data_b1 = 32'h0000_1000;
   assign fpu_result1 = fpu_op_a1 ^ fpu_op_b1;

   rom_vector_sequencer #(.W(W), .NUM_VECTORS(1024)) dut1 (
      .clk(clk), .rst(rst), .start(start1), .rom_address(rom_address1),
      .rom_data_a(rom_data_a1), .rom_data_b(rom_data_b1),
      .fpu_op_a(fpu_op_a1), .fpu_op_b(fpu_op_b1), .fpu_begin(fpu_begin1),
      .fpu_ready(rdy1), .fpu_result(fpu_result1),
      .tx_valid(tx_valid1), .tx_data(tx_data1), .tx_ready(1'b1),
      .busy(busy1), .done(done1), .vec_index(vec_index1), .checksum(checksum1)
   );

   // ---------------- monitors (pre-edge values at the active edge) ----------------
   int           cyc = 0;
   int           nbeg0 = 0, nhs0 = 0, ndone0 = 0, last_hs0 = 0, done_cyc0 = 0;
   int           nhs1 = 0, ndone1 = 0;
   logic [9:0]   last_addr1 = '0;
   logic [W-1:0] seq0 [0:7];

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (fpu_begin0) nbeg0 <= nbeg0 + 1;
      if (tx_valid0 && tx_ready0) begin
         nhs0          <= nhs0 + 1;
         seq0[nhs0 % 8] <= tx_data0;
         last_hs0      <= cyc;
      end
      if (done0) begin
         ndone0    <= ndone0 + 1;
         done_cyc0 <= cyc;
      end
      if (tx_valid1) nhs1 <= nhs1 + 1;
      if (done1) ndone1 <= ndone1 + 1;
      if (busy1) last_addr1 <= rom_address1;
   end

   task automatic pulse0();
      @(posedge clk); #1 start0 = 1'b1;
      @(posedge clk); #1 start0 = 1'b0;
   endtask

   task automatic pulse1();
      @(posedge clk); #1 start1 = 1'b1;
      @(posedge clk); #1 start1 = 1'b0;
   endtask

   logic [W-1:0] exp_sum;
   int t, base_b, base_h, base_d, bad;

   initial begin
`ifdef ROMSEQ_CHECKSUM_EN
      exp_sum = 32'd8;
`else
      exp_sum = 32'd0;
`endif
      // 1. reset and idle
      repeat (3) @(negedge clk);
      chk("rst_ctl", {busy0, tx_valid0, fpu_begin0, done0}, 4'b0);
      chk("rst_addr_idx", {rom_address0, vec_index0}, 20'd0);
      chk("rst_data", {tx_data0, fpu_op_a0}, 64'd0);
      chk("rst_cksum", checksum0, 32'd0);
      @(posedge clk); #1 rst = 1'b0;
      force_rdy = 1'b1;
      tx_ready0 = 1'b1;
      repeat (10) @(negedge clk);
      chk("idle_no_begin", nbeg0, 0);
      chk("idle_busy", busy0, 1'b0);
      force_rdy = 1'b0;

      // 2. basic 4-vector run
      pulse0();
      t = 0;
      while (ndone0 == 0 && t < 200) begin @(negedge clk); t++; end
      chk("run_timeout", t < 200, 1'b1);
      @(negedge clk);
      chk("run_begins", nbeg0, 4);
      chk("run_hs", nhs0, 4);
      chk("run_d0", seq0[0], 32'd1);
      chk("run_d1", seq0[1], 32'd4);
      chk("run_d2", seq0[2], 32'd7);
      chk("run_d3", seq0[3], 32'd10);
      chk("run_done_cnt", ndone0, 1);
      chk("run_done_lat", done_cyc0 - last_hs0, 1);
      chk("run_end_state", {busy0, done0, rom_address0}, 12'd0);
      chk("run_cksum", checksum0, exp_sum);

      // 3. back-pressure in vector 0
      tx_ready0 = 1'b0;
      base_b = nbeg0; base_h = nhs0; base_d = ndone0;
      pulse0();
      t = 0;
      while (!tx_valid0 && t < 50) begin @(negedge clk); t++; end
      chk("bp_valid_timeout", t < 50, 1'b1);
      bad = 0;
      repeat (20) begin
         @(negedge clk);
         if (!(tx_valid0 && tx_data0 == 32'd1 && rom_address0 == 10'd0)) bad++;
      end
      chk("bp_hold", bad, 0);
      chk("bp_one_begin", nbeg0 - base_b, 1);
      @(posedge clk); #1 tx_ready0 = 1'b1;
      t = 0;
      while (vec_index0 != 10'd1 && t < 20) begin @(negedge clk); t++; end
      chk("bp_next_idx", vec_index0, 10'd1);
      chk("bp_next_addr", rom_address0, 10'd1);
      t = 0;
      while (ndone0 == base_d && t < 200) begin @(negedge clk); t++; end
      chk("bp_done", ndone0 - base_d, 1);
      chk("bp_hs", nhs0 - base_h, 4);
      @(negedge clk);
      chk("bp_cksum", checksum0, exp_sum);

      // 4. start during WAIT of vector 2 is ignored
      base_b = nbeg0; base_h = nhs0; base_d = ndone0;
      pulse0();
      t = 0;
      while (vec_index0 != 10'd2 && t < 100) begin @(negedge clk); t++; end
      chk("ign_reach_v2", vec_index0, 10'd2);
      repeat (2) @(negedge clk);
      pulse0();
      t = 0;
      while (ndone0 == base_d && t < 200) begin @(negedge clk); t++; end
      repeat (10) @(negedge clk);
      chk("ign_begins", nbeg0 - base_b, 4);
      chk("ign_hs", nhs0 - base_h, 4);
      chk("ign_done", ndone0 - base_d, 1);
      chk("ign_idle", busy0, 1'b0);

      // 5. full depth on the 1024 instance
      pulse1();
      t = 0;
      while (ndone1 == 0 && t < 6000) begin @(negedge clk); t++; end
      chk("full_timeout", t < 6000, 1'b1);
      @(negedge clk);
      chk("full_hs", nhs1, 1024);
      chk("full_last_addr", last_addr1, 10'd1023);
      chk("full_idle_addr", rom_address1, 10'd0);
      chk("full_idle_busy", busy1, 1'b0);

      // 6. reset during WAIT of vector 5
      base_d = ndone1;
      pulse1();
      t = 0;
      while (vec_index1 != 10'd5 && t < 100) begin @(negedge clk); t++; end
      chk("rst6_reach_v5", vec_index1, 10'd5);
      rdy1 = 1'b0;
      repeat (4) @(negedge clk);
      chk("rst6_in_wait", {busy1, tx_valid1, fpu_begin1}, 3'b100);
      @(posedge clk); #1 rst = 1'b1;
      @(negedge clk);
      chk("rst6_ctl", {busy1, tx_valid1, fpu_begin1, done1}, 4'b0);
      chk("rst6_addr_idx", {rom_address1, vec_index1}, 20'd0);
      chk("rst6_data", {tx_data1, fpu_op_a1}, 64'd0);
      @(posedge clk); #1 rst = 1'b0;
      rdy1 = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst6_no_done", ndone1 - base_d, 0);
      pulse1();
      t = 0;
      while (!fpu_begin1 && t < 20) begin @(negedge clk); t++; end
      chk("rst6_restart_addr", rom_address1, 10'd0);
      chk("rst6_restart_op", fpu_op_a1, 32'd0);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
